// File: rtl/clk_div_ctrl.sv
// Run-time divided-clock generator with glitch-free divisor changes, start and stop.
// Latency: clk_out rises cur_half cycles after run is sampled in STOP; config applies at the next period boundary.
// Backpressure: cfg_ready drops while one config is pending and returns the cycle after it is applied.
module clk_div_ctrl #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_HALF = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] cur_half
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] L_ONE          = WIDTH'(1);
    localparam logic [WIDTH-1:0] L_DEFAULT_HALF = WIDTH'(DEFAULT_HALF);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic [WIDTH-1:0] r_cur_half;
    logic [WIDTH-1:0] r_pend_half;
    logic             r_pending;

    logic             w_accept;
    logic [WIDTH-1:0] w_half_in;
    logic             w_wrap;
    logic             w_stop_now;

    // Handshake, zero clamp, end-of-half-period and safe-stop detection
    assign w_accept   = cfg_valid && !r_pending;
    assign w_half_in  = (cfg_half == '0) ? L_ONE : cfg_half;
    assign w_wrap     = (r_cnt == (r_cur_half - L_ONE));
    // Low phase may be cut short (no edge is lost); high phase must finish first
    assign w_stop_now = !r_clk_out &&
                        (((r_state == ST_RUN) && !run) || (r_state == ST_DRAIN));

    // Controller FSM: counter, divided clock, tick and half-period bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_STOP;
            r_cnt       <= '0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_cur_half  <= L_DEFAULT_HALF;
            r_pend_half <= L_DEFAULT_HALF;
            r_pending   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                    // A value accepted on the STOP entry edge lands here
                    if (r_pending) begin
                        r_cur_half <= r_pend_half;
                        r_pending  <= 1'b0;
                    end else if (w_accept) begin
                        r_cur_half <= w_half_in;
                    end
                    if (run) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (w_stop_now) begin
                        r_state   <= ST_STOP;
                        r_cnt     <= '0;
                        r_clk_out <= 1'b0;
                        if (r_pending) begin
                            r_cur_half <= r_pend_half;
                            r_pending  <= 1'b0;
                        end else if (w_accept) begin
                            r_pend_half <= w_half_in;
                            r_pending   <= 1'b1;
                        end
                    end else begin
                        if (w_wrap) begin
                            r_cnt     <= '0;
                            r_clk_out <= !r_clk_out;
                            if (!r_clk_out) begin
                                r_tick <= 1'b1;
                            end else if (r_pending) begin
                                // Period boundary: the counter restarts at 0 with the new value
                                r_cur_half <= r_pend_half;
                                r_pending  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + L_ONE;
                        end
                        // Mutually exclusive with the apply above since it needs !r_pending
                        if (w_accept) begin
                            r_pend_half <= w_half_in;
                            r_pending   <= 1'b1;
                        end
                        // Here clk_out is high: finish the high phase before stopping
                        if ((r_state == ST_RUN) && !run) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_STOP;
                end
            endcase
        end
    end

    assign cfg_ready = !r_pending;
    assign busy      = (r_state != ST_STOP);
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign cur_half  = r_cur_half;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: cycle-exact vector table plus multi-cycle phase measurements.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Every wait is bounded so the run always reaches its summary line.
module tb_clk_div_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic        cfg_valid;
    logic [15:0] cfg_half;
    logic        cfg_ready;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic [15:0] cur_half;

    int n_tests;
    int n_fail;

    clk_div_ctrl #(.WIDTH(16), .DEFAULT_HALF(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_half  (cur_half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        cv;
        logic [15:0] half;
        logic        e_clk;
        logic        e_tick;
        logic        e_busy;
        logic        e_rdy;
        logic [15:0] e_cur;
    } vec_t;

    vec_t vt[25];

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] h,
                                input logic ec, input logic et, input logic eb,
                                input logic er, input logic [15:0] ecur);
        vec_t x;
        x.run = r; x.cv = v; x.half = h;
        x.e_clk = ec; x.e_tick = et; x.e_busy = eb; x.e_rdy = er; x.e_cur = ecur;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive samples (including the current one) at which clk_out == lvl
    task automatic phase_len(input logic lvl, output int n);
        n = 0;
        while (clk_out === lvl && n < 300) begin
            n++;
            step();
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 16'd0;

        // run, cfg_valid, cfg_half | clk_out, tick, busy, cfg_ready, cur_half
        vt[0]  = mk(0, 1, 16'd0, 0, 0, 0, 1, 16'd1);   // zero clamps to 1
        vt[1]  = mk(0, 1, 16'd3, 0, 0, 0, 1, 16'd3);   // STOP write is direct
        vt[2]  = mk(1, 0, 16'd0, 0, 0, 1, 1, 16'd3);   // E0
        vt[3]  = mk(1, 0, 16'd0, 0, 0, 1, 1, 16'd3);
        vt[4]  = mk(1, 0, 16'd0, 0, 0, 1, 1, 16'd3);
        vt[5]  = mk(1, 0, 16'd0, 1, 1, 1, 1, 16'd3);   // rise at E0+3
        vt[6]  = mk(1, 1, 16'd2, 1, 0, 1, 0, 16'd3);   // 2 accepted, now pending
        vt[7]  = mk(1, 1, 16'd9, 1, 0, 1, 0, 16'd3);   // 9 held off
        vt[8]  = mk(1, 1, 16'd9, 0, 0, 1, 1, 16'd2);   // fall: 2 applied
        vt[9]  = mk(1, 1, 16'd9, 0, 0, 1, 0, 16'd2);   // 9 accepted
        vt[10] = mk(1, 0, 16'd0, 1, 1, 1, 0, 16'd2);
        vt[11] = mk(1, 0, 16'd0, 1, 0, 1, 0, 16'd2);
        vt[12] = mk(1, 0, 16'd0, 0, 0, 1, 1, 16'd9);   // fall: 9 applied
        vt[13] = mk(0, 0, 16'd0, 0, 0, 0, 1, 16'd9);   // low-phase stop, no pulse
        vt[14] = mk(1, 1, 16'd1, 0, 0, 1, 1, 16'd1);   // cfg + start together
        vt[15] = mk(1, 0, 16'd0, 1, 1, 1, 1, 16'd1);
        vt[16] = mk(1, 0, 16'd0, 0, 0, 1, 1, 16'd1);
        vt[17] = mk(1, 0, 16'd0, 1, 1, 1, 1, 16'd1);
        vt[18] = mk(0, 0, 16'd0, 0, 0, 1, 1, 16'd1);   // drain: high phase ends
        vt[19] = mk(1, 0, 16'd0, 0, 0, 0, 1, 16'd1);   // STOP, run ignored
        vt[20] = mk(1, 0, 16'd0, 0, 0, 1, 1, 16'd1);   // run honoured
        vt[21] = mk(1, 0, 16'd0, 1, 1, 1, 1, 16'd1);
        vt[22] = mk(0, 1, 16'd6, 0, 0, 1, 0, 16'd1);   // cfg on the fall: pending
        vt[23] = mk(0, 0, 16'd0, 0, 0, 0, 1, 16'd6);   // applied at STOP entry
        vt[24] = mk(0, 0, 16'd0, 0, 0, 0, 1, 16'd6);

        // Reset values, checked while reset is still asserted
        #13;
        chk("rst.clk_out", clk_out, 0);
        chk("rst.tick", tick, 0);
        chk("rst.busy", busy, 0);
        chk("rst.cfg_ready", cfg_ready, 1);
        chk("rst.cur_half", cur_half, 24);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 25; i++) begin
            run       = vt[i].run;
            cfg_valid = vt[i].cv;
            cfg_half  = vt[i].half;
            step();
            chk($sformatf("v%0d.clk_out", i), clk_out, vt[i].e_clk);
            chk($sformatf("v%0d.tick", i), tick, vt[i].e_tick);
            chk($sformatf("v%0d.busy", i), busy, vt[i].e_busy);
            chk($sformatf("v%0d.cfg_ready", i), cfg_ready, vt[i].e_rdy);
            chk($sformatf("v%0d.cur_half", i), cur_half, vt[i].e_cur);
        end
        cfg_valid = 1'b0;

        // Default run: 24 low, 24 high, 24 low, tick at each rise
        reset_pulse();
        run = 1'b1;
        step();
        phase_len(1'b0, n);
        chk("def.first_low", n, 24);
        chk("def.tick1", tick, 1);
        chk("def.cur_half", cur_half, 24);
        phase_len(1'b1, n);
        chk("def.high", n, 24);
        phase_len(1'b0, n);
        chk("def.low", n, 24);
        chk("def.tick2", tick, 1);

        // Mid-run reconfig to 5 in the first cycle of a high phase
        cfg_valid = 1'b1;
        cfg_half  = 16'd5;
        step();
        cfg_valid = 1'b0;
        chk("recfg.ready_low", cfg_ready, 0);
        chk("recfg.cur_old", cur_half, 24);
        phase_len(1'b1, n);
        chk("recfg.high_rest", n, 23);
        chk("recfg.cur_new", cur_half, 5);
        chk("recfg.ready_back", cfg_ready, 1);
        phase_len(1'b0, n);
        chk("recfg.low5", n, 5);
        chk("recfg.tick", tick, 1);
        phase_len(1'b1, n);
        chk("recfg.high5", n, 5);

        // Stop 3 cycles into a high phase with h=10
        run = 1'b0;
        reset_pulse();
        cfg_valid = 1'b1;
        cfg_half  = 16'd10;
        step();
        cfg_valid = 1'b0;
        chk("drain.cur", cur_half, 10);
        run = 1'b1;
        step();
        phase_len(1'b0, n);
        chk("drain.low", n, 10);
        step();
        step();
        run = 1'b0;
        phase_len(1'b1, n);
        chk("drain.high_rest", n, 8);
        chk("drain.busy_at_fall", busy, 1);
        step();
        chk("drain.busy_after", busy, 0);
        chk("drain.clk_after", clk_out, 0);

        // Reset during a high phase with a config pending
        run = 1'b1;
        step();
        phase_len(1'b0, n);
        chk("rstmid.low", n, 10);
        cfg_valid = 1'b1;
        cfg_half  = 16'd3;
        step();
        cfg_valid = 1'b0;
        chk("rstmid.pending", cfg_ready, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("rstmid.clk_out", clk_out, 0);
        chk("rstmid.tick", tick, 0);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.cfg_ready", cfg_ready, 1);
        chk("rstmid.cur_half", cur_half, 24);
        #2;
        reset = 1'b0;
        step();
        phase_len(1'b0, n);
        chk("rstmid.low24", n, 24);
        phase_len(1'b1, n);
        chk("rstmid.high24", n, 24);
        chk("rstmid.cur_kept", cur_half, 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the system's divided clocks. It produces a divided clock output whose half-period can be reprogrammed over a valid/ready configuration port. Divisor changes, starts and stops take effect only at safe points, so `clk_out` never shows a runt pulse. It sits between the CPU-side control registers and the logic clocked or enabled by the divided clock, and emits a one-cycle `tick` at every rising edge of `clk_out`.

## Interface
- `WIDTH`, 16: width of the half-period counter and of the configuration value.
- `DEFAULT_HALF`, 24: half-period loaded at reset, in `clk` cycles. Must be in the range 1..2^WIDTH-1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level request: 1 = produce the divided clock, 0 = park `clk_out` low.
- `cfg_valid`  in  1  a new half-period is offered.
- `cfg_half`  in  WIDTH  new half-period in `clk` cycles. The value 0 is clamped to 1.
- `cfg_ready`  out  1  controller can accept a configuration this cycle.
- `clk_out`  out  1  divided clock, registered. Period = 2*`cur_half` cycles, 50% duty.
- `tick`  out  1  one-cycle pulse, high in the same cycle `clk_out` first reads 1.
- `busy`  out  1  state is not STOP.
- `cur_half`  out  WIDTH  half-period currently in effect.

## Operation
- Reset values:
  - state = STOP, counter = 0, `clk_out` = 0, `tick` = 0.
  - `cur_half` = `pend_half` = DEFAULT_HALF, `pending` = 0, `cfg_ready` = 1, `busy` = 0.
- Config handshake:
  - A transfer occurs on a cycle where `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = !`pending`.
  - `cfg_valid` may be held across cycles. Only one value is ever pending.
- STOP:
  - An accepted config writes `cur_half` directly in the same cycle; `pending` stays 0.
  - If `run`=1: go to RUN with counter = 0 and `clk_out` = 0. A config accepted in that same cycle governs the first half-period.
- RUN, each cycle:
  - If counter == `cur_half`-1: counter ← 0 and `clk_out` toggles. Otherwise counter increments.
  - Low→high toggle: `tick` = 1 for that cycle.
  - High→low toggle (the period boundary): if `pending`, then `cur_half` ← `pend_half`, `pending` ← 0, and `cfg_ready` returns to 1 the next cycle.
  - An accepted config sets `pend_half` and sets `pending` to 1.
- Stop handling:
  - `run`=0 while `clk_out`=0 in RUN: go to STOP the next cycle. The low phase is truncated, which is glitch-free.
  - `run`=0 while `clk_out`=1: go to DRAIN.
- DRAIN:
  - Counting continues until the high→low toggle, then go to STOP with `clk_out`=0.
  - Any pending config is applied at that toggle.
  - `run` reasserting during DRAIN has no effect until STOP is reached. It is then honoured the following cycle.
- Entering STOP with `pending`=1 applies `pend_half` at the entry edge.
- Simultaneous events:
  - A config accepted in the same cycle as a high→low toggle is not applied at that toggle. It waits for the next period boundary (or STOP entry).
  - A new `cur_half` is only ever consumed from counter = 0, so counter overrun cannot occur.
- Reset mid-operation forces all reset values immediately. Any pending config is discarded.

## Timing
- `run` sampled high at edge E0 (state STOP):
  - `clk_out` rises at edge E0+h, where h = `cur_half`; `tick` is high for cycle E0+h.
  - Falls at E0+2h, rises at E0+3h, and so on.
- `cur_half`=1: `clk_out` toggles every cycle (period 2). `tick` is high every other cycle.
- Config latency:
  - In STOP: `cur_half` updates 1 edge after acceptance.
  - In RUN: `cur_half` updates at the first high→low toggle strictly after acceptance. This is at most 2h_old cycles later.
- Stop latency:
  - ≤1 cycle from the low phase.
  - ≤h cycles from the high phase, plus 1 edge to STOP.
- `busy` falls on the edge at which state becomes STOP.

## Test plan
- **Default run:** reset, then `run`=1 → `clk_out` period 48 cycles, 24 high / 24 low. `tick` once per period, coincident with the first high cycle. `cur_half`=24.
- **Mid-run reconfig:** with `run`=1, offer `cfg_half`=5 while `clk_out`=1 → `cfg_ready` drops the next cycle. `clk_out` completes its 24-cycle high phase. The next low phase and all later phases are 5 cycles. `cfg_ready`=1 again after that boundary.
- **Back-pressure:** offer 7 and then 9 back-to-back in RUN → 7 is accepted, 9 is held off (`cfg_ready`=0) until 7 is applied. 9 is then accepted and applied at the following boundary.
- **Stop in high phase / stop in low phase:**
  - Drop `run` 3 cycles into a high phase with h=10 → `clk_out` stays high 7 more cycles, then falls; `busy`=0 the next edge.
  - Drop `run` in a low phase → STOP the next cycle with `clk_out`=0 and no high pulse.
- **Zero / minimum config:** in STOP, `cfg_half`=0 → `cur_half`=1. `run`=1 → `clk_out` alternates every cycle; `tick` every 2 cycles.
- **Reset mid-operation:** assert `reset` during a high phase with a config pending → `clk_out`=0, `tick`=0, `busy`=0, `cfg_ready`=1 and `cur_half`=24 immediately, without waiting for a clock edge. The pending value is never applied.
